// File: rtl/mem_burst_initiator.sv
// mem_burst_initiator: sole master of the byte-addressed memory port, sequencing single/burst reads and writes.
// Optional busy-protocol checking is compiled in when MEM_BUSY_CHECK_EN is defined; otherwise err is tied low.
module mem_burst_initiator #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_rw,
    input  logic [1:0]        req_size,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic [1:0]        mem_access_size,
    output logic              mem_rw,
    output logic              mem_enable,
    input  logic              mem_busy,
    input  logic [DATA_W-1:0] mem_data_out
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, TAIL} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic [4:0]        beats_left_q, beats_left_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;
    logic              done_q, done_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_pend_last_q, rd_pend_last_d;
    logic              err_q, err_d;
    logic              accept, beat, last_beat;

    assign accept    = req_valid && req_ready;
    assign beat      = mem_enable;
    assign last_beat = beat && (beats_left_q == 5'd1);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = req_rw ? READ : WRITE;
            WRITE:   if (last_beat) state_d = IDLE;
            READ:    if (last_beat) state_d = TAIL;
            TAIL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read data is registered one cycle after the memory presents it, so a two-stage pending pipe tracks each beat.
    always_comb begin
        addr_d       = addr_q;
        size_d       = size_q;
        beats_left_d = beats_left_q;
        wdata_d      = wdata_q;
        if (accept) begin
            addr_d = req_addr & ~ADDR_W'(3);
            size_d = req_size;
            case (req_size)
                2'b00:   beats_left_d = 5'd1;
                2'b01:   beats_left_d = 5'd4;
                2'b10:   beats_left_d = 5'd8;
                default: beats_left_d = 5'd16;
            endcase
        end else if (beat) begin
            addr_d       = addr_q + ADDR_W'(4);
            beats_left_d = beats_left_q - 5'd1;
        end
        if (state_q == WRITE) wdata_d = wr_data;
        rd_pend_d      = (state_q == READ);
        rd_pend_last_d = (state_q == READ) && last_beat;
        rd_valid_d     = rd_pend_q;
        rd_last_d      = rd_pend_q && rd_pend_last_q;
        rd_data_d      = rd_pend_q ? mem_data_out : rd_data_q;
        done_d         = ((state_q == WRITE) && last_beat) || (rd_pend_q && rd_pend_last_q);
    end

`ifdef MEM_BUSY_CHECK_EN
    // Memory must report busy on every burst beat except the last one.
    always_comb begin
        err_d = err_q;
        if (beat && (size_q != 2'b00) && (last_beat ? mem_busy : !mem_busy)) err_d = 1'b1;
    end
`else
    logic unused_mem_busy;
    assign unused_mem_busy = mem_busy;
    assign err_d = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr_q         <= '0;
            size_q         <= '0;
            beats_left_q   <= '0;
            wdata_q        <= '0;
            rd_data_q      <= '0;
            rd_valid_q     <= 1'b0;
            rd_last_q      <= 1'b0;
            done_q         <= 1'b0;
            rd_pend_q      <= 1'b0;
            rd_pend_last_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            addr_q         <= addr_d;
            size_q         <= size_d;
            beats_left_q   <= beats_left_d;
            wdata_q        <= wdata_d;
            rd_data_q      <= rd_data_d;
            rd_valid_q     <= rd_valid_d;
            rd_last_q      <= rd_last_d;
            done_q         <= done_d;
            rd_pend_q      <= rd_pend_d;
            rd_pend_last_q <= rd_pend_last_d;
            err_q          <= err_d;
        end
    end

    // req_ready is held off during the done cycle so a new request lands strictly after completion.
    always_comb begin
        req_ready   = (state_q == IDLE) && !done_q;
        wr_ready    = (state_q == WRITE);
        mem_enable  = 1'b0;
        mem_rw      = 1'b1;
        mem_data_in = wdata_q;
        case (state_q)
            WRITE: begin
                mem_enable  = wr_valid;
                mem_rw      = 1'b0;
                mem_data_in = wr_data;
            end
            READ:    mem_enable = 1'b1;
            default: ;
        endcase
    end

    assign mem_address     = addr_q;
    assign mem_access_size = size_q;
    assign rd_data         = rd_data_q;
    assign rd_valid        = rd_valid_q;
    assign rd_last         = rd_last_q;
    assign done            = done_q;
    assign err             = err_q;
endmodule

// File: tb/tb_mem_burst_initiator.sv
// Scoreboard testbench for mem_burst_initiator with a simple pattern memory model.
// Build with MEM_BUSY_CHECK_EN defined to exercise the busy-protocol error flag.
module tb_mem_burst_initiator;
    logic        clock;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_rw;
    logic [1:0]  req_size;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_last;
    logic        done;
    logic        err;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [1:0]  mem_access_size;
    logic        mem_rw;
    logic        mem_enable;
    logic        mem_busy;
    logic [31:0] mem_data_out;

    int testsRun;
    int failCount;
    bit expErr;
    bit busyCheckOn;

    logic [63:0] expWrQ[$];
    logic [31:0] expRdAddrQ[$];
    logic [32:0] expRdQ[$];
    logic [63:0] monWr;
    logic [32:0] monRd;
    logic [31:0] monAddr;

    mem_burst_initiator #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_rw(req_rw), .req_size(req_size),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
        .done(done), .err(err),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_access_size(mem_access_size), .mem_rw(mem_rw), .mem_enable(mem_enable),
        .mem_busy(mem_busy), .mem_data_out(mem_data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] patternOf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory model: read data appears the cycle after a read beat; other cycles carry junk.
    always @(posedge clock) begin
        if (mem_enable && mem_rw) mem_data_out <= patternOf(mem_address);
        else mem_data_out <= 32'hBAD0_0BAD;
    end

    // Scoreboard: every write beat, read beat and read word is matched against queued expectations.
    always @(negedge clock) begin
        if (mem_enable && !mem_rw) begin
            if (expWrQ.size() == 0) checkOutput("wrBeatUnexpected", 1, 0);
            else begin
                monWr = expWrQ.pop_front();
                checkOutput("wrAddr", mem_address, monWr[63:32]);
                checkOutput("wrData", mem_data_in, monWr[31:0]);
            end
        end
        if (mem_enable && mem_rw) begin
            if (expRdAddrQ.size() == 0) checkOutput("rdBeatUnexpected", 1, 0);
            else begin
                monAddr = expRdAddrQ.pop_front();
                checkOutput("rdAddr", mem_address, monAddr);
            end
        end
        if (rd_valid) begin
            if (expRdQ.size() == 0) checkOutput("rdValidUnexpected", 1, 0);
            else begin
                monRd = expRdQ.pop_front();
                checkOutput("rdData", rd_data, monRd[31:0]);
                checkOutput("rdLast", rd_last, monRd[32]);
            end
        end
    end

    // Runs one transfer; called and returns at 2 time units after a rising edge.
    task automatic applyStimulus(input logic rw, input logic [1:0] size, input logic [31:0] addr,
                                 input int gapAt, input int gapLen, input int busyFault,
                                 input int abortAt, input bit noisyReq, input logic [31:0] firstData);
        int n;
        int i;
        int gapDone;
        bit ok;
        logic [31:0] base;
        logic [31:0] wdat [16];
        n = (size == 2'b00) ? 1 : (size == 2'b01) ? 4 : (size == 2'b10) ? 8 : 16;
        base = addr & ~32'd3;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clock);
            if (req_ready) ok = 1'b1;
            else begin @(posedge clock); #2; end
        end
        checkOutput("reqReadyWait", {63'd0, ok}, 1);
        if (!ok) return;
        for (int j = 0; j < n; j++) begin
            if (rw) begin
                expRdAddrQ.push_back(base + 32'(4 * j));
                expRdQ.push_back({(j == n - 1), patternOf(base + 32'(4 * j))});
            end else begin
                wdat[j] = (j == 0) ? firstData : $urandom;
                expWrQ.push_back({base + 32'(4 * j), wdat[j]});
            end
        end
        req_valid = 1'b1;
        req_addr  = addr;
        req_rw    = rw;
        req_size  = size;
        @(posedge clock); #2;
        if (noisyReq) begin
            req_addr = 32'h1234_5670;
            req_rw   = ~rw;
        end else req_valid = 1'b0;

        if (!rw) begin
            i = 0;
            gapDone = 0;
            while (i < n) begin
                if (i == gapAt && gapDone < gapLen) begin
                    wr_valid = 1'b0;
                    mem_busy = 1'b0;
                    gapDone++;
                end else begin
                    wr_valid = 1'b1;
                    wr_data  = wdat[i];
                    mem_busy = (n > 1) && (i != n - 1);
                    if (i == busyFault) begin
                        mem_busy = 1'b0;
                        if (busyCheckOn && n > 1) expErr = 1'b1;
                    end
                    i++;
                end
                @(negedge clock);
                checkOutput("wrEnable", mem_enable, wr_valid);
                checkOutput("wrReady", wr_ready, 1);
                checkOutput("wrEarlyDone", done, 0);
                checkOutput("wrAccSize", mem_access_size, size);
                if (wr_valid) checkOutput("wrRw", mem_rw, 0);
                @(posedge clock); #2;
            end
            wr_valid = 1'b0;
            mem_busy = 1'b0;
            @(negedge clock);
            checkOutput("wrDone", done, 1);
            checkOutput("wrEnableAfter", mem_enable, 0);
            checkOutput("wrReadyDuringDone", req_ready, 0);
            @(posedge clock); #2;
            @(negedge clock);
            checkOutput("wrDoneOnce", done, 0);
            checkOutput("wrReqReadyBack", req_ready, 1);
            @(posedge clock); #2;
            checkOutput("wrQueueEmpty", expWrQ.size(), 0);
        end else begin
            for (int c = 1; c <= n + 3; c++) begin
                if (noisyReq && c == n) req_valid = 1'b0;
                mem_busy = (n > 1) && (c < n);
                if (c == abortAt) begin
                    resetn = 1'b0;
                    #1;
                    checkOutput("abortEnable", mem_enable, 0);
                    checkOutput("abortRdValid", rd_valid, 0);
                    checkOutput("abortDone", done, 0);
                    checkOutput("abortAddr", mem_address, 0);
                    checkOutput("abortRw", mem_rw, 1);
                    checkOutput("abortSize", mem_access_size, 0);
                    checkOutput("abortReqReady", req_ready, 1);
                    expRdQ.delete();
                    expRdAddrQ.delete();
                    expErr = 1'b0;
                    mem_busy = 1'b0;
                    @(posedge clock); #2;
                    @(posedge clock); #2;
                    resetn = 1'b1;
                    for (int q = 0; q < 4; q++) begin
                        @(negedge clock);
                        checkOutput("postAbortRdValid", rd_valid, 0);
                        checkOutput("postAbortDone", done, 0);
                        checkOutput("postAbortReady", req_ready, 1);
                        @(posedge clock); #2;
                    end
                    return;
                end
                @(negedge clock);
                checkOutput("rdEnable", mem_enable, (c <= n));
                if (c <= n) begin
                    checkOutput("rdRw", mem_rw, 1);
                    checkOutput("rdAccSize", mem_access_size, size);
                end
                checkOutput("rdValidTiming", rd_valid, (c >= 3 && c <= n + 2));
                checkOutput("rdDoneTiming", done, (c == n + 2));
                checkOutput("rdReqReady", req_ready, (c >= n + 3));
                @(posedge clock); #2;
            end
            mem_busy = 1'b0;
            checkOutput("rdQueueEmpty", expRdQ.size(), 0);
            checkOutput("rdAddrQueueEmpty", expRdAddrQ.size(), 0);
        end
        checkOutput("errState", err, expErr);
    endtask

    initial begin
        testsRun  = 0;
        failCount = 0;
        expErr    = 1'b0;
        busyCheckOn = 1'b0;
`ifdef MEM_BUSY_CHECK_EN
        busyCheckOn = 1'b1;
`endif
        resetn    = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_rw    = 1'b0;
        req_size  = '0;
        wr_data   = '0;
        wr_valid  = 1'b0;
        mem_busy  = 1'b0;
        @(posedge clock); #2;
        @(negedge clock);
        checkOutput("rstReqReady", req_ready, 1);
        checkOutput("rstEnable", mem_enable, 0);
        checkOutput("rstRw", mem_rw, 1);
        checkOutput("rstAddr", mem_address, 0);
        checkOutput("rstSize", mem_access_size, 0);
        checkOutput("rstRdValid", rd_valid, 0);
        checkOutput("rstRdData", rd_data, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstErr", err, 0);
        @(posedge clock); #2;
        resetn = 1'b1;
        @(posedge clock); #2;

        applyStimulus(1'b0, 2'b00, 32'h8002_0000, -1, 0, -1, 0, 1'b0, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 2'b01, 32'h8002_0013, 2, 2, -1, 0, 1'b0, 32'h0BAD_F00D);
        applyStimulus(1'b1, 2'b11, 32'h8002_0040, -1, 0, -1, 0, 1'b0, 32'h0);
        applyStimulus(1'b1, 2'b01, 32'hFFFF_FFF8, -1, 0, -1, 0, 1'b1, 32'h0);
        applyStimulus(1'b1, 2'b10, 32'h8002_0080, -1, 0, -1, 5, 1'b0, 32'h0);
        applyStimulus(1'b1, 2'b00, 32'h8002_0101, -1, 0, -1, 0, 1'b0, 32'h0);
        applyStimulus(1'b0, 2'b10, 32'h8002_0200, -1, 0, 2, 0, 1'b0, 32'h1357_9BDF);
        applyStimulus(1'b0, 2'b01, 32'h8002_0300, -1, 0, -1, 0, 1'b0, 32'h2468_ACE0);
        applyStimulus(1'b1, 2'b01, 32'h8002_0400, -1, 0, -1, 0, 1'b0, 32'h0);

        resetn = 1'b0;
        expErr = 1'b0;
        #1;
        checkOutput("finalRstErr", err, 0);
        @(posedge clock); #2;
        resetn = 1'b1;
        @(negedge clock);
        checkOutput("finalReqReady", req_ready, 1);
        checkOutput("finalErr", err, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end
endmodule

// File: doc/mem_burst_initiator.md
# mem_burst_initiator

Initiator side of the byte-addressed instruction/data memory port. Accepts one transfer request (single word or 4/8/16-word burst, read or write) from a processor-side client and sequences the memory port one word per beat: address stepping, `access_size`/`rw`/`enable` generation, and capture of returned read data. Sits between the fetch/load-store logic and the memory block, as the only master on that port.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: word width. Each beat moves one word, which is 4 bytes.

Ports:
- `clock`  in  1  single clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  transfer request.
- `req_ready`  out  1  high in IDLE only. The request is accepted when `req_valid && req_ready`.
- `req_addr`  in  ADDR_W  start byte address. Bits [1:0] are ignored and forced to 0.
- `req_rw`  in  1  1 = read, 0 = write.
- `req_size`  in  2  00 = 1 word, 01 = 4, 10 = 8, 11 = 16.
- `wr_data`  in  DATA_W  write word.
- `wr_valid`  in  1  write word present.
- `wr_ready`  out  1  high in WRITE.
- `rd_data`  out  DATA_W  read word.
- `rd_valid`  out  1  one-cycle strobe per read word. There is no backpressure.
- `rd_last`  out  1  qualifies the final `rd_valid` of a burst.
- `done`  out  1  one-cycle pulse when a transfer completes.
- `err`  out  1  sticky busy-protocol error (see Configuration).
- `mem_address`  out  ADDR_W  current beat address.
- `mem_data_in`  out  DATA_W  write data to memory.
- `mem_access_size`  out  2  latched `req_size`, held for the whole transfer.
- `mem_rw`  out  1  1 = read, 0 = write.
- `mem_enable`  out  1  a beat is issued in any cycle where this is high.
- `mem_busy`  in  1  memory burst-busy flag.
- `mem_data_out`  in  DATA_W  memory read data, valid the cycle after a read beat.

## Operation
States: IDLE, WRITE, READ, TAIL.

IDLE
- On request accept, latch the following:
  - `addr` = `req_addr & ~3`;
  - `rw`;
  - `size`;
  - `beats_left` = 1/4/8/16 (5-bit counter).
- Then go to READ if `rw` = 1, otherwise WRITE.

WRITE
- Drive `mem_enable = wr_valid`, `mem_rw = 0`, `mem_data_in = wr_data`.
- Each cycle with `wr_valid` is one beat: `addr += 4` and `beats_left -= 1`.
- On the beat where `beats_left == 1`: assert `done` next cycle and go to IDLE.
- While `wr_valid` = 0 the transfer stalls with `mem_enable` low.

READ
- Drive `mem_enable = 1` and `mem_rw = 1` every cycle. One beat per cycle, with `addr += 4` and `beats_left -= 1`.
- After the beat where `beats_left == 1`, go to TAIL.

TAIL
- A single cycle with `mem_enable` low.
- Capture the final data, then go to IDLE.

Read data return
- Each issued read beat k registers `rd_data <= mem_data_out` and asserts `rd_valid` one cycle after `mem_data_out` becomes valid, i.e. two cycles after beat k.
- `rd_last` accompanies the final word.
- `done` pulses in the same cycle as the final `rd_valid`.

Datapath rules
- `mem_address` = `addr`. It wraps modulo 2^ADDR_W and does not saturate.
- Outside WRITE/READ: `mem_enable` = 0, `mem_rw` = 1, and `mem_data_in` holds its last value.
- A new request cannot be accepted before `done`. `req_ready` returns high in the cycle after `done`.

## Timing
- Reset (asynchronous, immediate, including mid-burst) forces:
  - state = IDLE;
  - `beats_left` = 0, `addr` = 0;
  - `rd_valid` = `rd_last` = `done` = `err` = 0, `rd_data` = 0;
  - `mem_enable` = 0, `mem_rw` = 1, `mem_access_size` = 0.
- After reset `req_ready` = 1. No partial `rd_valid`/`done` is emitted for an aborted burst.
- Write burst of N words with `wr_valid` held high: N consecutive enable cycles. `done` comes 1 cycle after the last beat.
- Read burst of N words:
  - beats on cycles 1..N after accept;
  - `rd_valid` on cycles 3..N+2;
  - `done` and `rd_last` on cycle N+2.
- Single-word transfers have the same timing with N = 1.
- `req_valid` during a transfer is ignored and not queued.

## Configuration
- `MEM_BUSY_CHECK_EN` defined:
  - On every issued beat of a multi-word burst, `mem_busy` is sampled.
  - `err` is set if `mem_busy` = 0 on any beat other than the last, or `mem_busy` = 1 on the last beat.
  - `err` stays set until reset. Transfers still complete normally.
  - Single-word transfers are not checked.
- `MEM_BUSY_CHECK_EN` undefined: `mem_busy` is unused and `err` is tied to 0.

## Test plan
- Reset, then a single write of 0xDEADBEEF to 0x80020000: one enable cycle with `mem_rw` = 0 and `mem_address` = 0x80020000; `done` 1 cycle later; `req_ready` high the cycle after.
- 4-word write to 0x80020013 with `wr_valid` low for 2 cycles mid-burst:
  - addresses 0x80020010/14/18/1C;
  - `mem_enable` low during the gap;
  - exactly 4 beats, then `done`.
- 16-word read of a preloaded pattern at 0x80020040:
  - 16 consecutive enables;
  - `rd_valid` on cycles 3–18 with data in address order;
  - `rd_last` and `done` on cycle 18.
- Read burst starting at 0xFFFFFFF8 with size 01: addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- `resetn` dropped on beat 5 of an 8-word read:
  - outputs go to reset values immediately;
  - no further `rd_valid` or `done`;
  - a new request is accepted after release.
- With `MEM_BUSY_CHECK_EN`: an 8-word write with `mem_busy` forced to 0 on beat 3 sets `err` = 1, `done` still pulses, and `err` holds until reset. Without the macro, `err` stays 0.
